// File: rtl/ks_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ks_pkg                                                   |
// | Description : Shared types and width helpers for the chunked adder     |
// |               sequencer and its arbiter.                               |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+

package ks_pkg;

    localparam int c_N_DEFAULT      = 16;
    localparam int c_CHUNKS_DEFAULT = 4;
    localparam int c_NREQ_DEFAULT   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int f_idw(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int f_w(input int n, input int chunks);
        return n * chunks;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rr_arbiter                                               |
// | Description : Combinational round-robin picker; search starts at ptr,  |
// |               returns one-hot grant plus encoded winner index.         |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+

module rr_arbiter
    import ks_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int IDW  = f_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int w_slot;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_slot = 0;
        if (en) begin
            for (int i = 0; i < NREQ; i++) begin
                w_slot = (int'(ptr) + i) % NREQ;
                if (!any && req[w_slot]) begin
                    any           = 1'b1;
                    grant[w_slot] = 1'b1;
                    idx           = IDW'(w_slot);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ks_add_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ks_add_sequencer                                         |
// | Description : Time-shares one external N-bit adder slice among NREQ    |
// |               requesters, rippling a W-bit add/sub one chunk a cycle.  |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+

module ks_add_sequencer
    import ks_pkg::*;
#(
    parameter int N      = c_N_DEFAULT,
    parameter int CHUNKS = c_CHUNKS_DEFAULT,
    parameter int NREQ   = c_NREQ_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*f_w(N,CHUNKS)-1:0]  req_a,
    input  logic [NREQ*f_w(N,CHUNKS)-1:0]  req_b,
    input  logic [NREQ-1:0]                req_sub,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [f_idw(NREQ)-1:0]         rsp_id,
    output logic [f_w(N,CHUNKS)-1:0]       rsp_sum,
    output logic                           rsp_cout,
    output logic                           rsp_ovf,
    output logic                           busy,
    output logic [N-1:0]                   add_a,
    output logic [N-1:0]                   add_b,
    output logic                           add_cin,
    input  logic [N-1:0]                   add_sum,
    input  logic                           add_cout
);

    localparam int c_W   = f_w(N, CHUNKS);
    localparam int c_IDW = f_idw(NREQ);
    localparam int c_CW  = f_idw(CHUNKS);
    localparam logic [c_CW-1:0]  c_LAST_CHUNK = c_CW'(CHUNKS - 1);
    localparam logic [c_IDW-1:0] c_LAST_REQ   = c_IDW'(NREQ - 1);

    state_t                   r_state_q, w_state_d;
    logic [c_IDW-1:0]         r_ptr_q,   w_ptr_d;
    logic [c_IDW-1:0]         r_id_q,    w_id_d;
    logic [c_CW-1:0]          r_cnt_q,   w_cnt_d;
    logic                     r_carry_q, w_carry_d;
    logic                     r_sub_q,   w_sub_d;
    logic [CHUNKS-1:0][N-1:0] r_a_q,     w_a_d;
    logic [CHUNKS-1:0][N-1:0] r_b_q,     w_b_d;
    logic [CHUNKS-1:0][N-1:0] r_sum_q,   w_sum_d;

    logic [NREQ-1:0]  w_grant;
    logic [c_IDW-1:0] w_win;
    logic             w_any;
    logic [c_W-1:0]   w_sel_a;
    logic [c_W-1:0]   w_sel_b;
    logic             w_sel_sub;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (c_IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr_q),
        .en    (r_state_q == S_IDLE),
        .grant (w_grant),
        .idx   (w_win),
        .any   (w_any)
    );

    // Grant is one-hot, so an OR-of-ANDs is enough to mux the winner's operands.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a   = w_sel_a | req_a[i*c_W +: c_W];
                w_sel_b   = w_sel_b | req_b[i*c_W +: c_W];
                w_sel_sub = w_sel_sub | req_sub[i];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_id_d    = r_id_q;
        w_cnt_d   = r_cnt_q;
        w_carry_d = r_carry_q;
        w_sub_d   = r_sub_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sum_d   = r_sum_q;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_any) begin
                    w_a_d     = w_sel_a;
                    w_b_d     = w_sel_b ^ {c_W{w_sel_sub}};
                    w_sub_d   = w_sel_sub;
                    w_id_d    = w_win;
                    w_ptr_d   = (w_win == c_LAST_REQ) ? '0 : w_win + 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                // B is stored pre-inverted, so subtraction only needs cin=1 on chunk 0.
                add_a   = r_a_q[r_cnt_q];
                add_b   = r_b_q[r_cnt_q];
                add_cin = (r_cnt_q == '0) ? r_sub_q : r_carry_q;
                w_sum_d[r_cnt_q] = add_sum;
                w_carry_d        = add_cout;
                if (r_cnt_q == c_LAST_CHUNK) begin
                    w_cnt_d   = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_ptr_q   <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
            r_carry_q <= 1'b0;
            r_sub_q   <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_id_q    <= w_id_d;
            r_cnt_q   <= w_cnt_d;
            r_carry_q <= w_carry_d;
            r_sub_q   <= w_sub_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = (r_state_q == S_DONE);
    assign busy      = (r_state_q != S_IDLE);
    assign rsp_id    = r_id_q;
    assign rsp_sum   = r_sum_q;
    assign rsp_cout  = r_carry_q;
    assign rsp_ovf   = (r_a_q[CHUNKS-1][N-1] == r_b_q[CHUNKS-1][N-1]) &&
                       (r_sum_q[CHUNKS-1][N-1] != r_a_q[CHUNKS-1][N-1]);

    // A requester must keep its request up until it is granted.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

`default_nettype wire

// File: tb/tb_ks_add_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ks_add_sequencer                                      |
// | Description : Self-checking bench with an arithmetic reference model.  |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+

module tb_ks_add_sequencer;

    localparam int c_N = 16;
    localparam int c_CHUNKS = 4;
    localparam int c_NREQ = 4;
    localparam int c_W = c_N * c_CHUNKS;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [c_NREQ-1:0]      req_valid = '0;
    logic [c_NREQ-1:0]      req_ready;
    logic [c_NREQ*c_W-1:0]  req_a = '0;
    logic [c_NREQ*c_W-1:0]  req_b = '0;
    logic [c_NREQ-1:0]      req_sub = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [1:0]             rsp_id;
    logic [c_W-1:0]         rsp_sum;
    logic                   rsp_cout;
    logic                   rsp_ovf;
    logic                   busy;
    logic [c_N-1:0]         add_a;
    logic [c_N-1:0]         add_b;
    logic                   add_cin;
    logic [c_N-1:0]         add_sum;
    logic                   add_cout;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    always #5 clk = ~clk;

    // The shared adder slice itself lives outside the sequencer.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    ks_add_sequencer #(
        .N      (c_N),
        .CHUNKS (c_CHUNKS),
        .NREQ   (c_NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    function automatic logic [63:0] m_sum(input logic [63:0] a, input logic [63:0] b, input logic sub);
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic m_cout(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [64:0] t;
        if (sub) return (a >= b);
        t = {1'b0, a} + {1'b0, b};
        return t[64];
    endfunction

    // Overflow: the exact signed result does not survive truncation to 64 bits.
    function automatic logic m_ovf(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic signed [65:0] sa, sb, r;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        r  = sub ? (sa - sb) : (sa + sb);
        return (r != $signed({{2{r[63]}}, r[63:0]}));
    endfunction

    // Carry entering chunk k of the full-width a + (sub ? ~b : b) + sub.
    function automatic logic m_cin(input logic [63:0] a, input logic [63:0] b, input logic sub, input int k);
        logic [63:0] beff, mask;
        logic [64:0] t;
        if (k == 0) return sub;
        beff = sub ? ~b : b;
        mask = (64'd1 << (16 * k)) - 64'd1;
        t = {1'b0, a & mask} + {1'b0, beff & mask} + {64'd0, sub};
        return t[16 * k];
    endfunction

    function automatic int m_winner(input logic [3:0] valid, input int ptr);
        for (int off = 0; off < 4; off++) begin
            if (valid[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    // Drives one request on requester id; optionally holds rsp_ready low for
    // 'hold' DONE cycles while another requester (pend >= 0) waits.
    task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input int hold, input int pend);
        int n;
        int w;
        logic [3:0]  exp_grant;
        logic [63:0] beff, es;
        logic        ec, eo, ecin;
        beff = sub ? ~b : b;
        es   = m_sum(a, b, sub);
        ec   = m_cout(a, b, sub);
        eo   = m_ovf(a, b, sub);
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_sub[id]   = sub;
        req_valid[id] = 1'b1;
        rsp_ready     = (hold == 0);
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        w = m_winner(req_valid, mptr);
        exp_grant = (w < 0) ? 4'b0 : (4'b0001 << w);
        checks++;
        if (req_ready !== exp_grant || w != id) begin
            errors++;
            $display("FAIL grant req%0d: req_ready=%b required=%b", id, req_ready, exp_grant);
            @(posedge clk); #1;
            req_valid[id] = 1'b0;
            return;
        end
        mptr = (id + 1) % 4;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        // Four RUN cycles, one chunk each.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ecin = m_cin(a, b, sub, k);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0 || add_a !== a[k*16 +: 16] ||
                add_b !== beff[k*16 +: 16] || add_cin !== ecin) begin
                errors++;
                $display("FAIL chunk%0d req%0d: add_a=%h add_b=%h add_cin=%b rsp_valid=%b busy=%b required add_a=%h add_b=%h add_cin=%b rsp_valid=0 busy=1",
                         k, id, add_a, add_b, add_cin, rsp_valid, busy, a[k*16 +: 16], beff[k*16 +: 16], ecin);
            end
        end
        if (pend >= 0) req_valid[pend] = 1'b1;
        // Fifth sampled cycle after accept: result valid.
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_cout !== ec || rsp_ovf !== eo || rsp_id !== 2'(id) ||
            add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL result req%0d: valid=%b sum=%h cout=%b ovf=%b id=%0d add=%h/%h/%b required valid=1 sum=%h cout=%b ovf=%b id=%0d add=0",
                     id, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, add_a, add_b, add_cin, es, ec, eo, id);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_id !== 2'(id) || rsp_cout !== ec ||
                rsp_ovf !== eo || busy !== 1'b1 || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall%0d req%0d: valid=%b sum=%h id=%0d busy=%b req_ready=%b required valid=1 sum=%h id=%0d busy=1 req_ready=0",
                         h, id, rsp_valid, rsp_sum, rsp_id, busy, req_ready, es, id);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL release req%0d: busy=%b rsp_valid=%b required busy=0 rsp_valid=0", id, busy, rsp_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0 || rsp_sum !== 64'd0 || rsp_id !== 2'd0 ||
            rsp_cout !== 1'b0 || rsp_ovf !== 1'b0 || add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b rsp_valid=%b req_ready=%b sum=%h id=%0d cout=%b ovf=%b add=%h/%h/%b required all 0",
                     busy, rsp_valid, req_ready, rsp_sum, rsp_id, rsp_cout, rsp_ovf, add_a, add_b, add_cin);
        end
        rst = 1'b0;
        mptr = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b req_ready=%b required busy=0 req_ready=0", busy, req_ready);
        end
    endtask

    task automatic test_directed;
        run_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, -1);
        run_op(2, 64'd5, 64'd7, 1'b1, 0, -1);
        run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, -1);
        run_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, -1);
        run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, -1);
    endtask

    task automatic test_fairness;
        logic [63:0] q_sum[$];
        logic [1:0]  q_id[$];
        logic        q_c[$];
        logic        q_o[$];
        int          order[$];
        int          cyc;
        int          w;
        logic [3:0]  exp_grant;
        logic [63:0] a, b;
        logic        s;
        rsp_ready = 1'b1;
        foreach (order[i]) order.delete(i);
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                req_a[i*64 +: 64] = {$urandom, $urandom};
                req_b[i*64 +: 64] = {$urandom, $urandom};
                req_sub[i]   = 1'($urandom_range(0, 1));
                req_valid[i] = 1'b1;
            end
        end
        cyc = 0;
        #1;
        while (cyc < 300 && !(req_valid == 4'b0 && busy === 1'b0)) begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL onehot: req_ready=%b required at most one bit", req_ready);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (q_sum.size() == 0) begin
                    errors++;
                    $display("FAIL rr_rsp: unexpected response id=%0d sum=%h required none", rsp_id, rsp_sum);
                end else if (rsp_sum !== q_sum[0] || rsp_id !== q_id[0] || rsp_cout !== q_c[0] || rsp_ovf !== q_o[0]) begin
                    errors++;
                    $display("FAIL rr_rsp: id=%0d sum=%h cout=%b ovf=%b required id=%0d sum=%h cout=%b ovf=%b",
                             rsp_id, rsp_sum, rsp_cout, rsp_ovf, q_id[0], q_sum[0], q_c[0], q_o[0]);
                end
                if (q_sum.size() != 0) begin
                    void'(q_sum.pop_front()); void'(q_id.pop_front());
                    void'(q_c.pop_front());   void'(q_o.pop_front());
                end
            end
            if (req_ready != 4'b0) begin
                w = m_winner(req_valid, mptr);
                exp_grant = (w < 0) ? 4'b0 : (4'b0001 << w);
                checks++;
                if (req_ready !== exp_grant) begin
                    errors++;
                    $display("FAIL rr_grant: req_ready=%b required=%b", req_ready, exp_grant);
                end
                if (w >= 0) begin
                    a = req_a[w*64 +: 64]; b = req_b[w*64 +: 64]; s = req_sub[w];
                    q_sum.push_back(m_sum(a, b, s)); q_id.push_back(2'(w));
                    q_c.push_back(m_cout(a, b, s));  q_o.push_back(m_ovf(a, b, s));
                    order.push_back(w);
                    mptr = (w + 1) % 4;
                end
                @(posedge clk); #1;
                if (w >= 0) begin
                    if (order.size() < 5) begin
                        req_a[w*64 +: 64] = {$urandom, $urandom};
                        req_b[w*64 +: 64] = {$urandom, $urandom};
                        req_sub[w] = 1'($urandom_range(0, 1));
                    end else begin
                        req_valid[w] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 300 || order.size() != 7 || q_sum.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: cycles=%0d accepts=%0d pending=%0d required cycles<300 accepts=7 pending=0",
                     cyc, order.size(), q_sum.size());
        end
        checks++;
        if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 3 || order[3] != 0 || order[4] != 1) begin
            errors++;
            $display("FAIL rr_order: first accepts=%p required 0,1,3,0,1", order);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_stall;
        req_a[2*64 +: 64] = 64'd100;
        req_b[2*64 +: 64] = 64'd23;
        req_sub[2] = 1'b1;
        run_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 10, 2);
        run_op(2, 64'd100, 64'd23, 1'b1, 0, -1);
    endtask

    task automatic test_random;
        logic [63:0] a, b;
        int id;
        for (int i = 0; i < 16; i++) begin
            id = $urandom_range(0, 3);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 64'hFFFF_FFFF_FFFF_FFFF;
                2: b = {48'd0, 16'hFFFF - a[15:0] + 16'd1};
                default: ;
            endcase
            run_op(id, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        req_a[1*64 +: 64] = {$urandom, $urandom};
        req_b[1*64 +: 64] = {$urandom, $urandom};
        req_sub[1]   = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rst_setup: req_ready=%b required=0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        mptr = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0 ||
            rsp_sum !== 64'd0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b rsp_valid=%b add=%h/%h/%b sum=%h id=%0d required all 0",
                     busy, rsp_valid, add_a, add_b, add_cin, rsp_sum, rsp_id);
        end
        // Pointer back at 0 means requester 1 beats 3.
        req_a[3*64 +: 64] = {$urandom, $urandom};
        req_b[3*64 +: 64] = {$urandom, $urandom};
        req_sub[3]   = 1'b1;
        req_valid[3] = 1'b1;
        run_op(1, 64'd3, 64'd4, 1'b0, 0, -1);
        run_op(3, req_a[3*64 +: 64], req_b[3*64 +: 64], 1'b1, 0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fairness();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
